sdram_load_packer: RTL and testbench
====================================

SDRAM_LOAD_PACKER -- requirements
Module: sdram_load_packer

Interface
REQ-001 Parameter DEPTH, default 4, sets the FIFO depth in words; it SHALL be a power of 2 and at least 2.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 in_wr  in  1  byte write strobe, one byte per cycle.
REQ-005 in_addr  in  26  byte address; bit 0 selects the lane (0=[7:0], 1=[15:8]).
REQ-006 in_data  in  8  byte data.
REQ-007 in_ready  out  1  byte accepted this cycle if high.
REQ-008 flush  in  1  single-cycle pulse that pushes the partially filled word.
REQ-009 idle  out  1  no pending word, FIFO empty, FSM in S_IDLE, no flush outstanding.
REQ-010 overflow  out  1  sticky; set when in_wr is asserted while in_ready is low.
REQ-011 sd_addr  out  26 ([26:1])  word address to the SDRAM write channel.
REQ-012 sd_din  out  16  write data.
REQ-013 sd_be  out  2  byte enables; [0] is the low lane.
REQ-014 sd_rnw  out  1  constant 0.
REQ-015 sd_req  out  1  request level; the controller latches on the rising edge.
REQ-016 sd_ready  in  1  single-cycle completion pulse from the controller.

Function
REQ-017 Pending-word register {valid, addr[25:1], data[15:0], be[1:0]}: an accepted byte SHALL merge into the pending word when all of these hold: valid=1, addr[25:1] matches, and the lane's be bit is clear; data and be are updated in lane.
REQ-018 Otherwise, an accepted byte SHALL push the pending word (if valid) into the FIFO and start a new pending word holding only this byte, in the same cycle.
REQ-019 When be becomes 2'b11, the pending word SHALL be pushed on the next cycle without waiting for another byte.
REQ-020 Flush SHALL set flush_pend. It executes in the first cycle with no in_wr: the pending word is pushed if valid, then flush_pend clears. Flush with no valid pending word is a no-op.
REQ-021 FIFO pushes SHALL be at most one per cycle. in_ready SHALL equal (count != DEPTH) from registered count, and is low while an auto-push (REQ-019) is due and the FIFO is full.
REQ-022 in_wr while in_ready is low SHALL drop the byte, leave the pending word unchanged, and set overflow.
REQ-023 Request FSM: S_IDLE -> S_REQ when the FIFO is non-empty. S_REQ drives sd_req=1 with sd_addr/sd_din/sd_be taken from the FIFO head, held stable. S_REQ -> S_GAP on sd_ready, popping the head. S_GAP drives sd_req=0 for exactly one cycle, then -> S_IDLE.
REQ-024 Back-to-back words SHALL be spaced by at least 2 cycles of sd_req low.
REQ-025 A simultaneous push and pop SHALL leave count unchanged. FIFO pointers SHALL wrap modulo DEPTH.
REQ-026 sd_ready outside S_REQ SHALL be ignored.
REQ-027 Word order on the SDRAM side SHALL equal push order.

Reset
REQ-028 While reset_n=0, the block SHALL set: sd_req=0, sd_addr=0, sd_din=0, sd_be=0, in_ready=1, idle=1, overflow=0, FSM=S_IDLE, FIFO empty, pending valid=0, flush_pend=0.
REQ-029 Reset asserted mid-request SHALL abandon the word. sd_req drops asynchronously.

Configuration
REQ-030 Macro SDRAM_LOAD_PACKER_MERGE_EN.
- Defined: merging per REQ-017 to REQ-019.
- Undefined: every accepted byte is pushed directly as its own word with a single be bit, the pending register is absent, and flush only clears flush_pend.

Verification
REQ-031 Bytes 0x11@0x100 then 0x22@0x101 -> one request: sd_addr=0x080, sd_din=0x2211, sd_be=2'b11. Without the macro: two requests, be=01 then 10.
REQ-032 Byte 0x5A@0x203 then flush -> one request: sd_addr=0x101, sd_din[15:8]=0x5A, sd_be=2'b10; idle=1 afterwards.
REQ-033 sd_ready withheld, 10 bytes streamed to ascending even/odd addresses, DEPTH=4 -> in_ready falls after 4 queued words. An extra in_wr -> overflow=1 and that byte is never issued.
REQ-034 Byte 0x01@0x10 then 0x02@0x10 -> two words both at sd_addr=0x08, be=01, data 0x01 then 0x02, in that order.
REQ-035 reset_n low while sd_req=1 -> sd_req=0 immediately, idle=1. After release, a new byte is issued normally.

Source files
------------

// File: rtl/sdram_load_packer.sv
// rtl/sdram_load_packer.sv - packs a byte stream into 16-bit SDRAM write requests
// Byte merging into words is enabled by defining SDRAM_LOAD_PACKER_MERGE_EN.
module sdram_load_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_wr,
  input  logic [25:0] in_addr,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        idle,
  output logic        overflow,
  output logic [25:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_be,
  output logic        sd_rnw,
  output logic        sd_req,
  input  logic        sd_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;
  state_t state, state_nxt;

  logic [24:0]   fifo_addr [DEPTH];
  logic [15:0]   fifo_data [DEPTH];
  logic [1:0]    fifo_be   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic        full, push, pop, accept, lane;
  logic        flush_pend, flush_go, pend_valid;
  logic [24:0] push_addr;
  logic [15:0] push_data;
  logic [1:0]  push_be;

  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign accept   = in_wr && in_ready;
  assign lane     = in_addr[0];
  assign pop      = (state == S_REQ) && sd_ready;

`ifdef SDRAM_LOAD_PACKER_MERGE_EN
  logic [24:0] pend_addr;
  logic [15:0] pend_data;
  logic [1:0]  pend_be;
  logic        merge, auto_push;

  assign merge     = accept && pend_valid && (pend_addr == in_addr[25:1]) && !pend_be[lane];
  assign auto_push = !accept && pend_valid && (pend_be == 2'b11) && !full;
  // A flush holding a valid word must wait for FIFO space before it retires.
  assign flush_go  = flush_pend && !in_wr && !(pend_valid && full);
  assign push      = (accept && !merge && pend_valid) || auto_push || (flush_go && pend_valid);
  assign push_addr = pend_addr;
  assign push_data = pend_data;
  assign push_be   = pend_be;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      pend_be    <= '0;
    end else if (accept) begin
      if (merge) begin
        if (lane) pend_data[15:8] <= in_data;
        else      pend_data[7:0]  <= in_data;
        pend_be <= pend_be | (lane ? 2'b10 : 2'b01);
      end else begin
        pend_valid <= 1'b1;
        pend_addr  <= in_addr[25:1];
        pend_data  <= lane ? {in_data, 8'h00} : {8'h00, in_data};
        pend_be    <= lane ? 2'b10 : 2'b01;
      end
    end else if (auto_push || flush_go) begin
      pend_valid <= 1'b0;
    end
  end
`else
  assign pend_valid = 1'b0;
  assign flush_go   = flush_pend && !in_wr;
  assign push       = accept;
  assign push_addr  = in_addr[25:1];
  assign push_data  = lane ? {in_data, 8'h00} : {8'h00, in_data};
  assign push_be    = lane ? 2'b10 : 2'b01;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      flush_pend <= flush || (flush_pend && !flush_go);
      overflow   <= overflow || (in_wr && !in_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_be[wr_ptr]   <= push_be;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != '0) state_nxt = S_REQ;
      S_REQ:   if (sd_ready) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The head entry cannot change while in S_REQ, so the request fields stay stable.
  always_comb begin
    sd_req  = 1'b0;
    sd_addr = '0;
    sd_din  = '0;
    sd_be   = '0;
    if (state == S_REQ) begin
      sd_req  = 1'b1;
      sd_addr = {1'b0, fifo_addr[rd_ptr]};
      sd_din  = fifo_data[rd_ptr];
      sd_be   = fifo_be[rd_ptr];
    end
  end

  assign sd_rnw = 1'b0;
  assign idle   = !pend_valid && (count == '0) && (state == S_IDLE) && !flush_pend;

endmodule

// File: tb/tb_sdram_load_packer.sv
// tb/tb_sdram_load_packer.sv - self-checking bench for sdram_load_packer
// Expected words come from a byte-stream reference model and constant vector tables.
module tb_sdram_load_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_wr = 1'b0;
  logic        flush = 1'b0;
  logic        sd_ready = 1'b0;
  logic [25:0] in_addr = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, idle, overflow, sd_rnw, sd_req;
  logic [25:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_be;

  sdram_load_packer #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_wr(in_wr), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .idle(idle), .overflow(overflow),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_be(sd_be), .sd_rnw(sd_rnw),
    .sd_req(sd_req), .sd_ready(sd_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
  } word_t;

  typedef struct {
    logic [25:0] a0;
    logic [7:0]  d0;
    bit          two;
    logic [25:0] a1;
    logic [7:0]  d1;
    int          n;
    word_t       w0;
    word_t       w1;
  } vec_t;

  word_t got_q[$];
  word_t exp_q[$];
  vec_t  vt[5];
  int    total = 0;
  int    bad = 0;
  bit    resp_en = 1'b0;
  bit    m_pv = 1'b0;
  word_t m_word;
  bit    exp_ovf;
  int    sent;

`ifdef SDRAM_LOAD_PACKER_MERGE_EN
  localparam int EXP_SENT = 9;
`else
  localparam int EXP_SENT = 4;
`endif

  function automatic word_t mkw(input logic [25:0] a, input logic [15:0] d, input logic [1:0] b);
    word_t w;
    w.addr = a;
    w.din  = d;
    w.be   = b;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: bytes fill a word until its address changes or a lane repeats.
  task automatic model_byte(input logic [25:0] a, input logic [7:0] d);
    word_t w;
    w = mkw(a >> 1, a[0] ? {d, 8'h00} : {8'h00, d}, a[0] ? 2'b10 : 2'b01);
`ifdef SDRAM_LOAD_PACKER_MERGE_EN
    if (m_pv && m_word.addr == w.addr && (m_word.be & w.be) == 2'b00) begin
      m_word.be  = m_word.be | w.be;
      m_word.din = m_word.din | w.din;
    end else begin
      if (m_pv) exp_q.push_back(m_word);
      m_word = w;
      m_pv = 1'b1;
    end
    if (m_word.be == 2'b11) begin
      exp_q.push_back(m_word);
      m_pv = 1'b0;
    end
`else
    exp_q.push_back(w);
`endif
  endtask

  task automatic model_flush();
    if (m_pv) exp_q.push_back(m_word);
    m_pv = 1'b0;
  endtask

  task automatic compare_words(input string tag);
    logic [15:0] mask;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      mask = {{8{exp_q[i].be[1]}}, {8{exp_q[i].be[0]}}};
      chk({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_be"}, 64'(got_q[i].be), 64'(exp_q[i].be));
      chk({tag, "_din"}, 64'(got_q[i].din & mask), 64'(exp_q[i].din & mask));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [25:0] a, input logic [7:0] d);
    @(negedge clk);
    flush = 1'b0;
    in_wr = 1'b1;
    in_addr = a;
    in_data = d;
  endtask

  // Flush retires on the first edge with no write and FIFO space.
  task automatic do_flush();
    int n;
    @(negedge clk);
    in_wr = 1'b0;
    flush = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      flush = 1'b0;
      in_wr = 1'b0;
      n++;
    end while (!in_ready && n < 200);
    chk("flush_space_timeout", 64'(n < 200), 64'd1);
    model_flush();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < budget);
    chk({tag, "_idle_timeout"}, 64'(idle), 64'd1);
  endtask

  // Controller stand-in: random completion pulses, plus stray pulses while sd_req is low.
  initial begin
    logic  prev_req;
    word_t prev;
    int    low_cnt;
    prev_req = 1'b0;
    low_cnt = 99;
    prev = '0;
    forever begin
      @(negedge clk);
      sd_ready = 1'b0;
      if (!reset_n) begin
        prev_req = 1'b0;
        low_cnt = 99;
      end else if (sd_req) begin
        if (!prev_req) chk("req_gap", 64'(low_cnt >= 2), 64'd1);
        else           chk("req_stable", 64'({sd_addr, sd_din, sd_be}), 64'(prev));
        prev = {sd_addr, sd_din, sd_be};
        prev_req = 1'b1;
        low_cnt = 0;
        if (resp_en && $urandom_range(0, 2) == 0) begin
          sd_ready = 1'b1;
          got_q.push_back(prev);
        end
      end else begin
        prev_req = 1'b0;
        low_cnt++;
        if (resp_en && $urandom_range(0, 7) == 0) sd_ready = 1'b1;
      end
    end
  end

  initial begin
    int          r;
    logic [25:0] a;
    logic [7:0]  d;
    int          n;

`ifdef SDRAM_LOAD_PACKER_MERGE_EN
    vt[0] = '{26'h100, 8'h11, 1'b1, 26'h101, 8'h22, 1, mkw(26'h080, 16'h2211, 2'b11), mkw(0, 0, 0)};
    vt[1] = '{26'h203, 8'h5A, 1'b0, 26'h000, 8'h00, 1, mkw(26'h101, 16'h5A00, 2'b10), mkw(0, 0, 0)};
    vt[2] = '{26'h010, 8'h01, 1'b1, 26'h010, 8'h02, 2, mkw(26'h008, 16'h0001, 2'b01), mkw(26'h008, 16'h0002, 2'b01)};
    vt[3] = '{26'h301, 8'h33, 1'b1, 26'h300, 8'h44, 1, mkw(26'h180, 16'h3344, 2'b11), mkw(0, 0, 0)};
    vt[4] = '{26'h100, 8'h55, 1'b1, 26'h102, 8'h66, 2, mkw(26'h080, 16'h0055, 2'b01), mkw(26'h081, 16'h0066, 2'b01)};
`else
    vt[0] = '{26'h100, 8'h11, 1'b1, 26'h101, 8'h22, 2, mkw(26'h080, 16'h0011, 2'b01), mkw(26'h080, 16'h2200, 2'b10)};
    vt[1] = '{26'h203, 8'h5A, 1'b0, 26'h000, 8'h00, 1, mkw(26'h101, 16'h5A00, 2'b10), mkw(0, 0, 0)};
    vt[2] = '{26'h010, 8'h01, 1'b1, 26'h010, 8'h02, 2, mkw(26'h008, 16'h0001, 2'b01), mkw(26'h008, 16'h0002, 2'b01)};
    vt[3] = '{26'h301, 8'h33, 1'b1, 26'h300, 8'h44, 2, mkw(26'h180, 16'h3300, 2'b10), mkw(26'h180, 16'h0044, 2'b01)};
    vt[4] = '{26'h100, 8'h55, 1'b1, 26'h102, 8'h66, 2, mkw(26'h080, 16'h0055, 2'b01), mkw(26'h081, 16'h0066, 2'b01)};
`endif

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sd_req", 64'(sd_req), 64'd0);
    chk("rst_sd_addr", 64'(sd_addr), 64'd0);
    chk("rst_sd_din", 64'(sd_din), 64'd0);
    chk("rst_sd_be", 64'(sd_be), 64'd0);
    chk("rst_sd_rnw", 64'(sd_rnw), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    resp_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send_byte(vt[i].a0, vt[i].d0);
      if (vt[i].two) send_byte(vt[i].a1, vt[i].d1);
      do_flush();
      wait_idle("vec", 200);
      exp_q.push_back(vt[i].w0);
      if (vt[i].n == 2) exp_q.push_back(vt[i].w1);
      compare_words($sformatf("vec%0d", i));
      chk("vec_sd_req_low", 64'(sd_req), 64'd0);
    end

    // Backpressure: no completions until the FIFO has filled.
    resp_en = 1'b0;
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_wr = 1'b0;
      if (!in_ready) break;
      in_wr = 1'b1;
      in_addr = 26'h400 + 26'(i);
      in_data = 8'hA0 + 8'(i);
      model_byte(in_addr, in_data);
      sent++;
    end
    @(negedge clk);
    in_wr = 1'b0;
    chk("ovf_bytes_before_full", 64'(sent), 64'(EXP_SENT));
    chk("ovf_in_ready_low", 64'(in_ready), 64'd0);
    chk("ovf_not_yet", 64'(overflow), 64'd0);
    in_wr = 1'b1;
    in_addr = 26'h400 + 26'(sent);
    in_data = 8'hEE;
    @(negedge clk);
    in_wr = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    resp_en = 1'b1;
    do_flush();
    wait_idle("ovf", 500);
    compare_words("ovf");
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Reset while a request is outstanding.
    resp_en = 1'b0;
    send_byte(26'h020, 8'h77);
    do_flush();
    n = 0;
    while (!sd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_req_seen", 64'(sd_req), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_sd_req", 64'(sd_req), 64'd0);
    chk("rst_mid_idle", 64'(idle), 64'd1);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_overflow", 64'(overflow), 64'd0);
    chk("rst_mid_sd_addr", 64'(sd_addr), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_pv = 1'b0;
    got_q.delete();
    exp_q.delete();
    resp_en = 1'b1;
    send_byte(26'h031, 8'h88);
    model_byte(26'h031, 8'h88);
    do_flush();
    wait_idle("rst_after", 200);
    compare_words("rst_after");

    // Random traffic against the reference model.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_pv = 1'b0;
    exp_ovf = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        do_flush();
      end else begin
        @(negedge clk);
        flush = 1'b0;
        in_wr = 1'b0;
        if (r < 70 && (in_ready || r >= 62)) begin
          a = 26'h600 + 26'($urandom_range(0, 5));
          d = 8'($urandom);
          in_wr = 1'b1;
          in_addr = a;
          in_data = d;
          if (in_ready) model_byte(a, d);
          else          exp_ovf = 1'b1;
        end
      end
    end
    do_flush();
    wait_idle("rand", 2000);
    compare_words("rand");
    chk("rand_overflow", 64'(overflow), 64'(exp_ovf));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
